// File: rtl/timer_scheduler_pkg.sv
// timer_scheduler_pkg
//   Shared types and default parameter values for the timer scheduler:
//   per-channel run state, event-output FSM state and the default
//   prescaler ratio / channel count / counter width.
package timer_scheduler_pkg;

    localparam int DEF_RATIO = 50000;   // clk50m cycles per 1 ms tick
    localparam int DEF_NCH   = 4;       // timer channels
    localparam int DEF_CW    = 16;      // period/counter width in ticks

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    typedef enum logic {
        EMPTY = 1'b0,
        OFFER = 1'b1
    } evt_state_t;

endpackage

// File: rtl/timer_scheduler_prescaler.sv
// timer_scheduler_prescaler
//   Divides clk50m down to a one-cycle tick pulse every RATIO cycles.
//   The first pulse appears RATIO cycles after rst_n deasserts.
// Ports:
//   clk50m  in   system clock
//   rst_n   in   asynchronous active-low reset
//   tick    out  registered one-cycle pulse
module timer_scheduler_prescaler #(
    parameter int RATIO = 50000
) (
    input  logic clk50m,
    input  logic rst_n,
    output logic tick
);

    localparam int CNTW = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(RATIO - 1);

    logic [CNTW-1:0] cnt_r;
    logic            tick_r;

    // Free-running divider; the tick register fires on the wrap cycle.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNTW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler
//   NCH software-configured tick timers (one-shot or auto-reload) whose
//   expiries are queued as pending flags and offered one at a time on a
//   valid/ready event port, selected round-robin.
// Ports:
//   clk50m, rst_n          clock, asynchronous active-low reset
//   cfg_we/cfg_ch          config write strobe and target channel
//   cfg_period/periodic    period in ticks, 1 = auto-reload
//   start/stop             per-channel start / stop pulses (stop wins)
//   tick                   1 ms base tick
//   active                 channel is running
//   overrun                sticky: expiry while previous event still pending
//   evt_valid/evt_ch       offered expiry event and its channel
//   evt_ready              consumer accepts the offered event
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int RATIO = DEF_RATIO,
    parameter int NCH   = DEF_NCH,
    parameter int CW    = DEF_CW
) (
    input  logic                    clk50m,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [CW-1:0]           cfg_period,
    input  logic                    cfg_periodic,
    input  logic [NCH-1:0]          start,
    input  logic [NCH-1:0]          stop,
    output logic                    tick,
    output logic [NCH-1:0]          active,
    output logic [NCH-1:0]          overrun,
    output logic                    evt_valid,
    output logic [$clog2(NCH)-1:0]  evt_ch,
    input  logic                    evt_ready
);

    localparam int CHW = $clog2(NCH);

    logic            tick_s;
    ch_state_t       ch_state_r [NCH];
    ch_state_t       ch_state_s [NCH];
    logic [CW-1:0]   cnt_r      [NCH];
    logic [CW-1:0]   cnt_s      [NCH];
    logic [CW-1:0]   period_r   [NCH];
    logic [NCH-1:0]  periodic_r;
    logic [NCH-1:0]  pending_r;
    logic [NCH-1:0]  pending_s;
    logic [NCH-1:0]  overrun_r;
    logic [NCH-1:0]  overrun_s;
    logic [NCH-1:0]  active_r;
    logic [NCH-1:0]  expire_s;
    logic [NCH-1:0]  hs_clr_s;
    logic            hs_s;

    evt_state_t      evt_state_r;
    evt_state_t      evt_state_s;
    logic            evt_valid_r;
    logic [CHW-1:0]  evt_ch_r;
    logic [CHW-1:0]  evt_ch_s;
    logic [CHW-1:0]  ptr_r;
    logic [CHW-1:0]  ptr_s;
    logic [CHW-1:0]  sel_ch_s;
    logic [CHW-1:0]  rr_ch_s;
    logic            sel_any_s;
    int              rr_idx_s;

    timer_scheduler_prescaler #(
        .RATIO (RATIO)
    ) u_prescaler (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .tick   (tick_s)
    );

    // Config registers; a running count only sees a new period at its next reload.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                period_r[i] <= '0;
            end
            periodic_r <= '0;
        end else if (cfg_we && (int'(cfg_ch) < NCH)) begin
            period_r[cfg_ch]   <= cfg_period;
            periodic_r[cfg_ch] <= cfg_periodic;
        end
    end

    // Per-channel next state: stop > start > tick, plus expiry/pending/overrun.
    always_comb begin
        hs_s     = evt_valid_r & evt_ready;
        hs_clr_s = '0;
        if (hs_s) begin
            hs_clr_s[evt_ch_r] = 1'b1;
        end else begin
            hs_clr_s = '0;
        end
        for (int i = 0; i < NCH; i++) begin
            ch_state_s[i] = ch_state_r[i];
            cnt_s[i]      = cnt_r[i];
            expire_s[i]   = 1'b0;
            overrun_s[i]  = overrun_r[i];
            if (stop[i]) begin
                ch_state_s[i] = IDLE;
            end else if (start[i] && (period_r[i] != '0)) begin
                cnt_s[i]      = period_r[i];
                ch_state_s[i] = RUN;
                overrun_s[i]  = 1'b0;
            end else if (tick_s && (ch_state_r[i] == RUN)) begin
                if (cnt_r[i] == CW'(1)) begin
                    expire_s[i] = 1'b1;
                    // A period rewritten to 0 must not be reloaded: 0 is never legal in RUN.
                    if (periodic_r[i] && (period_r[i] != '0)) begin
                        cnt_s[i] = period_r[i];
                    end else begin
                        ch_state_s[i] = IDLE;
                    end
                end else begin
                    cnt_s[i] = cnt_r[i] - CW'(1);
                end
            end else begin
                ch_state_s[i] = ch_state_r[i];
            end
            // An expiry on the channel being handshaken this cycle is a fresh event, not an overrun.
            if (expire_s[i] && pending_r[i] && !hs_clr_s[i]) begin
                overrun_s[i] = 1'b1;
            end else begin
                overrun_s[i] = overrun_s[i];
            end
            pending_s[i] = (pending_r[i] & ~hs_clr_s[i]) | expire_s[i];
        end
    end

    // Channel state, counters and status flags.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                ch_state_r[i] <= IDLE;
                cnt_r[i]      <= '0;
            end
            pending_r <= '0;
            overrun_r <= '0;
            active_r  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ch_state_r[i] <= ch_state_s[i];
                cnt_r[i]      <= cnt_s[i];
                active_r[i]   <= (ch_state_s[i] == RUN);
            end
            pending_r <= pending_s;
            overrun_r <= overrun_s;
        end
    end

    // Round-robin pick: first pending channel at or after the pointer.
    always_comb begin
        sel_any_s = 1'b0;
        sel_ch_s  = '0;
        rr_idx_s  = 0;
        rr_ch_s   = '0;
        for (int k = 0; k < NCH; k++) begin
            rr_idx_s = int'(ptr_r) + k;
            if (rr_idx_s >= NCH) begin
                rr_idx_s = rr_idx_s - NCH;
            end else begin
                rr_idx_s = rr_idx_s;
            end
            rr_ch_s = CHW'(rr_idx_s);
            if (!sel_any_s && pending_r[rr_ch_s]) begin
                sel_any_s = 1'b1;
                sel_ch_s  = rr_ch_s;
            end else begin
                sel_any_s = sel_any_s;
            end
        end
    end

    // Event output FSM next state; evt_ch is frozen while offering.
    always_comb begin
        evt_state_s = evt_state_r;
        evt_ch_s    = evt_ch_r;
        ptr_s       = ptr_r;
        case (evt_state_r)
            EMPTY: begin
                if (sel_any_s) begin
                    evt_state_s = OFFER;
                    evt_ch_s    = sel_ch_s;
                end else begin
                    evt_state_s = EMPTY;
                end
            end
            OFFER: begin
                if (hs_s) begin
                    evt_state_s = EMPTY;
                    if (evt_ch_r == CHW'(NCH - 1)) begin
                        ptr_s = '0;
                    end else begin
                        ptr_s = evt_ch_r + CHW'(1);
                    end
                end else begin
                    evt_state_s = OFFER;
                end
            end
            default: begin
                evt_state_s = EMPTY;
            end
        endcase
    end

    // Event output FSM state register and registered event outputs.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            evt_state_r <= EMPTY;
            evt_valid_r <= 1'b0;
            evt_ch_r    <= '0;
            ptr_r       <= '0;
        end else begin
            evt_state_r <= evt_state_s;
            evt_valid_r <= (evt_state_s == OFFER);
            evt_ch_r    <= evt_ch_s;
            ptr_r       <= ptr_s;
        end
    end

    assign tick      = tick_s;
    assign active    = active_r;
    assign overrun   = overrun_r;
    assign evt_valid = evt_valid_r;
    assign evt_ch    = evt_ch_r;

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter RATIO, default 50000: clk50m cycles per tick (1 ms at 50 MHz), minimum 2.
REQ-002 SHALL have parameter NCH, default 4: number of timer channels, minimum 2.
REQ-003 SHALL have parameter CW, default 16: period/counter width in ticks.
REQ-004 SHALL have port clk50m  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_we  in  1  config write strobe, one cycle.
REQ-007 SHALL have port cfg_ch  in  $clog2(NCH)  channel addressed by cfg_we.
REQ-008 SHALL have port cfg_period  in  CW  period in ticks.
REQ-009 SHALL have port cfg_periodic  in  1  1 = auto-reload, 0 = one-shot.
REQ-010 SHALL have port start  in  NCH  per-channel start pulse.
REQ-011 SHALL have port stop  in  NCH  per-channel stop pulse.
REQ-012 SHALL have port tick  out  1  one-cycle pulse every RATIO cycles.
REQ-013 SHALL have port active  out  NCH  channel in RUN.
REQ-014 SHALL have port overrun  out  NCH  sticky, expiry while event still pending.
REQ-015 SHALL have port evt_valid  out  1  expiry event offered.
REQ-016 SHALL have port evt_ch  out  $clog2(NCH)  channel of offered event.
REQ-017 SHALL have port evt_ready  in  1  consumer accepts event.

Function
REQ-018 SHALL pulse tick high one cycle every RATIO cycles; first pulse RATIO cycles after rst_n deasserts.
REQ-019 SHALL, on cfg_we, store cfg_period/cfg_periodic for cfg_ch; a running count is unaffected until its next reload.
REQ-020 SHALL keep per channel state IDLE or RUN; active[i] = (state == RUN).
REQ-021 SHALL, on start[i] with stored period != 0, load counter with period and enter RUN (restart if already RUN); start[i] with period 0 is ignored.
REQ-022 SHALL, on tick in RUN: counter == 1 -> expire; else decrement by 1.
REQ-023 SHALL, on expiry: set pending[i]; periodic -> reload period, stay RUN; one-shot -> IDLE.
REQ-024 SHALL, on stop[i], enter IDLE without setting or clearing pending[i].
REQ-025 SHALL give stop priority over start in the same cycle; start over tick (reload, no decrement).
REQ-026 SHALL set overrun[i] when expiry occurs with pending[i] already set and not handshaken that cycle; pending stays one event; overrun[i] clears only on an accepted start[i].
REQ-027 SHALL run event output FSM EMPTY/OFFER: in EMPTY with any pending, select round-robin from pointer, register evt_ch, assert evt_valid next cycle.
REQ-028 SHALL hold evt_valid and evt_ch stable until evt_valid && evt_ready.
REQ-029 SHALL, on handshake, clear pending[evt_ch], set pointer = evt_ch+1 modulo NCH, return to EMPTY; next offer no earlier than the following cycle.
REQ-030 SHALL, on expiry of channel evt_ch in handshake cycle, keep pending set (new event), no overrun.
REQ-031 SHALL use modulo-2^CW counter arithmetic; counter never underflows since 0 is unreachable in RUN.

Reset
REQ-032 SHALL, on rst_n low, clear tick, active, overrun, evt_valid, evt_ch, pending, periods, periodic bits, pointer; all channels IDLE; FSM EMPTY; tick divider restarts.
REQ-033 SHALL, on reset mid-operation, drop pending events and offers without handshake.

Structure
REQ-034 SHALL place ch_state_t (IDLE, RUN), evt_state_t (EMPTY, OFFER) and default parameter constants in package timer_scheduler_pkg.
REQ-035 SHALL generate tick by instantiating the team prescaler module with ratio = RATIO.

Verification
REQ-036 SHALL verify RATIO=4, ch0 period 3 one-shot, start -> evt_valid, evt_ch=0 after 3rd tick; active[0] low afterwards.
REQ-037 SHALL verify ch1 period 2 periodic, evt_ready=1 -> one event every 8 cycles, no overrun, active[1] stays 1.
REQ-038 SHALL verify ch0..ch3 period 1 started together, evt_ready=1 -> events in order 0,1,2,3, evt_ch stable while evt_ready=0.
REQ-039 SHALL verify ch2 period 1 periodic, evt_ready=0 for 3 ticks -> overrun[2]=1, single event; start[2] clears overrun.
REQ-040 SHALL verify start[0] and stop[0] same cycle -> IDLE; start with period 0 -> active[0] stays 0.
REQ-041 SHALL verify rst_n low while evt_valid=1 -> all outputs 0 next cycle; first tick 4 cycles after release.
